// File: rtl/lcd_spi_pkg.sv
// lcd_spi_pkg: FSM states, default parameters and counter sizing shared by the LCD SPI serializer.
package lcd_spi_pkg;
   typedef enum logic [2:0] {INIT_LOW, INIT_WAIT, IDLE, SHIFT, HOLD, GAP} state_e;
   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_CLK_DIV      = 2;
   localparam int DEF_RST_LOW_CYC  = 500;
   localparam int DEF_RST_WAIT_CYC = 1000;
   localparam int DEF_CS_GAP_CYC   = 4;
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/lcd_spi_bl_pwm.sv
// lcd_spi_bl_pwm: 8-bit free-running backlight PWM, high while the counter is below the duty value.
module lcd_spi_bl_pwm import lcd_spi_pkg::*; (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] duty_i,
   output logic       pwm_o
);
   logic [7:0] cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_q + 8'd1;
   assign pwm_o = cnt_q < duty_i;
endmodule

// File: rtl/lcd_spi_serializer.sv
// lcd_spi_serializer: AXI-Stream to mode-3 SPI serializer for ST7789-class panels with reset sequencing.
// Define LCD_SPI_BL_PWM_EN to drive LCD_BLK from BL_DUTY via PWM; otherwise LCD_BLK is a plain enable.
module lcd_spi_serializer import lcd_spi_pkg::*; #(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
   parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC,
   parameter int CS_GAP_CYC   = DEF_CS_GAP_CYC
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                  S_AXIS_TUSER,
   input  logic                  S_AXIS_TLAST,
   input  logic                  S_AXIS_TVALID,
   output logic                  S_AXIS_TREADY,
   input  logic [7:0]            BL_DUTY,
   output logic                  BUSY,
   output logic                  LCD_RST,
   output logic                  LCD_BLK,
   output logic                  LCD_CS,
   output logic                  LCD_DC,
   output logic                  LCD_SDA,
   output logic                  LCD_SCK
);
   localparam int BW  = $clog2(DATA_WIDTH);
   localparam int DVW = $clog2(CLK_DIV + 1);
   localparam int CW  = cnt_width(RST_LOW_CYC, RST_WAIT_CYC, CS_GAP_CYC);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DVW-1:0]        div_q, div_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d, skid_data_q;
   logic                  last_q, last_d, skid_user_q, skid_last_q, skid_v_q, skid_v_d;
   logic                  rst_q, rst_d, blk_q, blk_d, cs_q, cs_d, sck_q, sck_d, sda_q, sda_d, dc_q, dc_d;
   logic                  load, accept, init_done, post_init_d, bl_on;

   assign init_done     = (state_q != INIT_LOW) && (state_q != INIT_WAIT);
   assign S_AXIS_TREADY = init_done & ~skid_v_q;
   assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
   assign skid_v_d      = accept | (skid_v_q & ~load);
   assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign BUSY          = (state_q == SHIFT) || (state_q == HOLD) || (state_q == GAP);
   assign post_init_d   = (state_d != INIT_LOW) && (state_d != INIT_WAIT);

`ifdef LCD_SPI_BL_PWM_EN
   lcd_spi_bl_pwm u_pwm (.clk_i(CLK), .rst_ni(RESETN), .duty_i(BL_DUTY), .pwm_o(bl_on));
`else
   logic unused_bl_duty;
   assign unused_bl_duty = ^BL_DUTY;
   assign bl_on = 1'b1;
`endif
   assign blk_d = post_init_d & bl_on;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      div_d   = div_q;
      sh_d    = sh_q;
      last_d  = last_q;
      rst_d   = rst_q;
      cs_d    = cs_q;
      sck_d   = sck_q;
      sda_d   = sda_q;
      dc_d    = dc_q;
      load    = 1'b0;
      case (state_q)
         INIT_LOW:
            if (cnt_q == CW'(RST_LOW_CYC - 1)) begin
               state_d = INIT_WAIT;
               rst_d   = 1'b1;
               cnt_d   = '0;
            end else cnt_d = cnt_inc;
         INIT_WAIT:
            if (cnt_q == CW'(RST_WAIT_CYC - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else cnt_d = cnt_inc;
         IDLE, HOLD: load = skid_v_q;
         SHIFT:
            // A bit ends after its high half; the next word's fall replaces the idle high phase.
            if (div_q == DVW'(CLK_DIV - 1)) begin
               div_d = '0;
               if (!sck_q) sck_d = 1'b1;
               else if (bit_q != BW'(DATA_WIDTH - 1)) begin
                  bit_d = bit_q + 1'b1;
                  sck_d = 1'b0;
                  sda_d = sh_q[DATA_WIDTH-1];
                  sh_d  = sh_q << 1;
               end else if (last_q) begin
                  state_d = GAP;
                  cs_d    = 1'b1;
                  sda_d   = 1'b1;
                  cnt_d   = '0;
               end else if (skid_v_q) load = 1'b1;
               else begin
                  state_d = HOLD;
                  sda_d   = 1'b1;
               end
            end else div_d = div_q + 1'b1;
         GAP:
            if (cnt_q == CW'(CS_GAP_CYC - 1)) state_d = IDLE;
            else cnt_d = cnt_inc;
         default: state_d = INIT_LOW;
      endcase
      if (load) begin
         state_d = SHIFT;
         cs_d    = 1'b0;
         sck_d   = 1'b0;
         sda_d   = skid_data_q[DATA_WIDTH-1];
         sh_d    = skid_data_q << 1;
         dc_d    = skid_user_q;
         last_d  = skid_last_q;
         bit_d   = '0;
         div_d   = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         state_q     <= INIT_LOW;
         cnt_q       <= '0;
         bit_q       <= '0;
         div_q       <= '0;
         sh_q        <= '0;
         last_q      <= 1'b0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         skid_user_q <= 1'b0;
         skid_last_q <= 1'b0;
         rst_q       <= 1'b0;
         blk_q       <= 1'b0;
         cs_q        <= 1'b1;
         sck_q       <= 1'b1;
         sda_q       <= 1'b1;
         dc_q        <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         sh_q     <= sh_d;
         last_q   <= last_d;
         skid_v_q <= skid_v_d;
         if (accept) begin
            skid_data_q <= S_AXIS_TDATA;
            skid_user_q <= S_AXIS_TUSER;
            skid_last_q <= S_AXIS_TLAST;
         end
         rst_q <= rst_d;
         blk_q <= blk_d;
         cs_q  <= cs_d;
         sck_q <= sck_d;
         sda_q <= sda_d;
         dc_q  <= dc_d;
      end

   assign LCD_RST = rst_q;
   assign LCD_BLK = blk_q;
   assign LCD_CS  = cs_q;
   assign LCD_DC  = dc_q;
   assign LCD_SDA = sda_q;
   assign LCD_SCK = sck_q;
endmodule

// File: tb/tb_lcd_spi_serializer.sv
// tb_lcd_spi_serializer: directed checks of an 8-bit and a 16-bit serializer instance sharing clock and reset.
module tb_lcd_spi_serializer;
   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  d8 = '0, bl_duty = 8'd64;
   logic [15:0] d16 = '0;
   logic        u8 = 0, l8 = 0, v8 = 0, u16 = 0, l16 = 0, v16 = 0;
   logic        tr8, busy8, rst8, blk8, cs8, dc8, sda8, sck8;
   logic        tr16, busy16, rst16, blk16, cs16, dc16, sda16, sck16;

   lcd_spi_serializer u_dut8 (
      .CLK(clk), .RESETN(rstn), .S_AXIS_TDATA(d8), .S_AXIS_TUSER(u8), .S_AXIS_TLAST(l8),
      .S_AXIS_TVALID(v8), .S_AXIS_TREADY(tr8), .BL_DUTY(bl_duty), .BUSY(busy8), .LCD_RST(rst8),
      .LCD_BLK(blk8), .LCD_CS(cs8), .LCD_DC(dc8), .LCD_SDA(sda8), .LCD_SCK(sck8));

   lcd_spi_serializer #(.DATA_WIDTH(16)) u_dut16 (
      .CLK(clk), .RESETN(rstn), .S_AXIS_TDATA(d16), .S_AXIS_TUSER(u16), .S_AXIS_TLAST(l16),
      .S_AXIS_TVALID(v16), .S_AXIS_TREADY(tr16), .BL_DUTY(bl_duty), .BUSY(busy16), .LCD_RST(rst16),
      .LCD_BLK(blk16), .LCD_CS(cs16), .LCD_DC(dc16), .LCD_SDA(sda16), .LCD_SCK(sck16));

   int vecs = 0, errs = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SPI-side monitors: words captured on SCK rises, bit spacing, CS low/high run lengths.
   logic [7:0]  sh8;
   logic [15:0] sh16;
   logic [8:0]  q8[$];
   logic [16:0] q16[$];
   int nb8 = 0, last8 = 0, bad8 = 0, lo8 = 0, hi8 = 0, lorun8 = 0, hirun8 = 0, falls8 = 0;
   int nb16 = 0, last16 = 0, bad16 = 0, lo16 = 0, hi16 = 0, lorun16 = 0, hirun16 = 0, falls16 = 0;
   bit p8s = 1, p8c = 1, hp8 = 0, p16s = 1, p16c = 1, hp16 = 0;

   always @(negedge clk) begin
      if (!rstn) begin
         nb8 = 0;
         hp8 = 0;
      end else if (sck8 && !p8s) begin
         sh8 = {sh8[6:0], sda8};
         nb8++;
         if (hp8 && int'($time / 10) - last8 != 4) bad8++;
         last8 = int'($time / 10);
         hp8 = 1;
         if (nb8 == 8) begin
            q8.push_back({dc8, sh8});
            nb8 = 0;
         end
      end
      if (cs8) begin
         if (!p8c) lorun8 = lo8;
         lo8 = 0;
         hi8++;
         hp8 = 0;
      end else begin
         if (p8c) begin
            hirun8 = hi8;
            falls8++;
         end
         hi8 = 0;
         lo8++;
      end
      p8s = sck8;
      p8c = cs8;
   end

   always @(negedge clk) begin
      if (!rstn) begin
         nb16 = 0;
         hp16 = 0;
      end else if (sck16 && !p16s) begin
         sh16 = {sh16[14:0], sda16};
         nb16++;
         if (hp16 && int'($time / 10) - last16 != 4) bad16++;
         last16 = int'($time / 10);
         hp16 = 1;
         if (nb16 == 16) begin
            q16.push_back({dc16, sh16});
            nb16 = 0;
         end
      end
      if (cs16) begin
         if (!p16c) lorun16 = lo16;
         lo16 = 0;
         hi16++;
         hp16 = 0;
      end else begin
         if (p16c) begin
            hirun16 = hi16;
            falls16++;
         end
         hi16 = 0;
         lo16++;
      end
      p16s = sck16;
      p16c = cs16;
   end

   task automatic send8(input logic [7:0] d, input logic u, input logic l);
      int n = 0;
      d8 = d; u8 = u; l8 = l; v8 = 1;
      while (!tr8 && n < 2000) begin @(negedge clk); n++; end
      check("send8_ready", n < 2000, 1);
      @(negedge clk);
   endtask

   task automatic send16(input logic [15:0] d, input logic u, input logic l);
      int n = 0;
      d16 = d; u16 = u; l16 = l; v16 = 1;
      while (!tr16 && n < 2000) begin @(negedge clk); n++; end
      check("send16_ready", n < 2000, 1);
      @(negedge clk);
   endtask

   task automatic init_seq(input string tag);
      int n = 0;
      while (!rst8 && n < 600) begin @(negedge clk); n++; end
      check({tag, "_rst_low"}, n, 500);
      n = 0;
      while (!tr8 && n < 1100) begin @(negedge clk); n++; end
      check({tag, "_rst_wait"}, n, 1000);
      check({tag, "_tready16"}, tr16, 1);
   endtask

   task automatic wait_done8(input int words);
      int n = 0;
      while ((q8.size() < words || busy8) && n < 3000) begin @(negedge clk); n++; end
      check("done8_tmo", n < 3000, 1);
   endtask

   task automatic wait_done16(input int words);
      int n = 0;
      while ((q16.size() < words || busy16) && n < 9000) begin @(negedge clk); n++; end
      check("done16_tmo", n < 9000, 1);
   endtask

   initial begin
      logic [15:0] w;
      int f0, n;
      repeat (3) @(negedge clk);
      check("reset_outs8", {rst8, blk8, cs8, sck8, sda8, dc8, tr8, busy8}, 8'b0011_1100);
      check("reset_outs16", {rst16, blk16, cs16, sck16, sda16, dc16, tr16, busy16}, 8'b0011_1100);
      rstn = 1;
      init_seq("init");
`ifndef LCD_SPI_BL_PWM_EN
      check("blk_on", blk8, 1);
`endif
      check("idle_busy", busy8, 0);

      send8(8'hA5, 0, 1);
      send8(8'h3C, 1, 1);
      v8 = 0;
      wait_done8(2);
      check("w8_a5", q8.size() > 0 ? q8.pop_front() : 9'h1ff, 9'h0A5);
      check("w8_3c", q8.size() > 0 ? q8.pop_front() : 9'h1ff, 9'h13C);
      check("cs_low8", lorun8, 32);
      check("cs_gap8", hirun8 >= 4, 1);
      check("bit_period8", bad8, 0);
      check("idle_sda8", {sda8, sck8, cs8}, 3'b111);

      f0 = falls16;
      bad16 = 0;
      for (int i = 0; i < 100; i++) send16(16'(i * 291) ^ 16'h5A00, i[0], i == 99);
      v16 = 0;
      wait_done16(100);
      for (int i = 0; i < 100; i++) begin
         w = 16'(i * 291) ^ 16'h5A00;
         check("w16_stream", q16.size() > 0 ? q16.pop_front() : 17'h1ffff, {i[0], w});
      end
      check("gapless16", bad16, 0);
      check("cs_frames16", falls16 - f0, 1);
      check("cs_low16", lorun16, 6400);

      f0 = falls16;
      send16(16'hBEEF, 1, 0);
      v16 = 0;
      repeat (120) @(negedge clk);
      check("hold_cs", cs16, 0);
      check("hold_sck", sck16, 1);
      check("hold_busy", busy16, 1);
      send16(16'h1234, 0, 1);
      v16 = 0;
      wait_done16(2);
      check("hold_w0", q16.size() > 0 ? q16.pop_front() : 17'h1ffff, 17'h1BEEF);
      check("hold_w1", q16.size() > 0 ? q16.pop_front() : 17'h1ffff, 17'h01234);
      check("hold_frames", falls16 - f0, 1);

      send8(8'h81, 1, 1);
      v8 = 0;
      n = 0;
      while (nb8 < 3 && n < 200) begin @(negedge clk); n++; end
      check("abort_reach", n < 200, 1);
      rstn = 0;
      #1;
      check("abort_outs8", {rst8, blk8, cs8, sck8, sda8, dc8, tr8, busy8}, 8'b0011_1100);
      repeat (2) @(negedge clk);
      rstn = 1;
      init_seq("reinit");
      repeat (200) @(negedge clk);
      check("no_resend", q8.size() + nb8, 0);

      n = 0;
`ifdef LCD_SPI_BL_PWM_EN
      repeat (256) begin @(negedge clk); n += int'(blk8); end
      check("pwm_duty64", n, 64);
      bl_duty = 8'd0;
      repeat (3) @(negedge clk);
      n = 0;
      repeat (256) begin @(negedge clk); n += int'(blk8); end
      check("pwm_duty0", n, 0);
`else
      repeat (256) begin @(negedge clk); n += int'(blk8); end
      check("blk_steady", n, 256);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
